// File: rtl/pulse_dsp_pkg.sv
// rtl/pulse_dsp_pkg.sv - shared widths and frame defaults for the pulse DSP chain
package pulse_dsp_pkg;

    // Sample and result widths shared with square_root_cal
    localparam int DEFAULT_DATA_WIDTH        = 16;
    localparam int DEFAULT_OUTPUT_DATA_WIDTH = 2 * DEFAULT_DATA_WIDTH;

    // Frame geometry
    localparam int DEFAULT_FRAME_LENGTH  = 1024;
    localparam int DEFAULT_COUNTER_WIDTH = $clog2(DEFAULT_FRAME_LENGTH);

endpackage

// File: rtl/signed_square_reg.sv
// rtl/signed_square_reg.sv - registered signed squarer with clock-enable and sync reset
module signed_square_reg #(
    parameter int WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [WIDTH-1:0]     din,
    output logic signed [2*WIDTH-1:0]   dout
);

    // Sign-extend first so the product is formed at full 2*WIDTH precision
    logic signed [2*WIDTH-1:0] din_ext;
    assign din_ext = {{WIDTH{din[WIDTH-1]}}, din};

    // Square register: cleared by reset, holds while enable is low
    always_ff @(posedge clock) begin
        if (reset) begin
            dout <= '0;
        end else if (enable) begin
            dout <= din_ext * din_ext;
        end
    end

endmodule

// File: rtl/magnitude_squared_cal.sv
// rtl/magnitude_squared_cal.sv - three-stage pipelined Re^2 + Im^2 with valid tag and frame marker
module magnitude_squared_cal
    import pulse_dsp_pkg::*;
#(
    parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
    parameter int OUTPUT_DATA_WIDTH = DEFAULT_OUTPUT_DATA_WIDTH,
    parameter int FRAME_LENGTH      = DEFAULT_FRAME_LENGTH,
    parameter int COUNTER_WIDTH     = DEFAULT_COUNTER_WIDTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            validIn,
    input  logic signed [DATA_WIDTH-1:0]    dataInRe,
    input  logic signed [DATA_WIDTH-1:0]    dataInIm,
    output logic                            validOut,
    output logic [OUTPUT_DATA_WIDTH-1:0]    dataOut,
    output logic                            lastOut
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(FRAME_LENGTH - 1);

    logic signed [DATA_WIDTH-1:0]   re_s1;
    logic signed [DATA_WIDTH-1:0]   im_s1;
    logic                           valid_s1;
    logic signed [2*DATA_WIDTH-1:0] sq_re_s2;
    logic signed [2*DATA_WIDTH-1:0] sq_im_s2;
    logic                           valid_s2;
    logic [COUNTER_WIDTH-1:0]       frame_count;
    logic [OUTPUT_DATA_WIDTH-1:0]   sum_s2;
    logic                           frame_end;

    // Both squares are nonnegative and below 2^(2*DATA_WIDTH-1), so the unsigned sum cannot overflow
    assign sum_s2    = OUTPUT_DATA_WIDTH'($unsigned(sq_re_s2)) + OUTPUT_DATA_WIDTH'($unsigned(sq_im_s2));
    assign frame_end = (frame_count == LAST_COUNT);

    // S1: capture the input sample and its valid tag
    always_ff @(posedge clock) begin
        if (reset) begin
            re_s1    <= '0;
            im_s1    <= '0;
            valid_s1 <= 1'b0;
        end else if (enable) begin
            re_s1    <= dataInRe;
            im_s1    <= dataInIm;
            valid_s1 <= validIn;
        end
    end

    // S2: register the two squares alongside the tag
    signed_square_reg #(.WIDTH(DATA_WIDTH)) u_square_re (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .din    (re_s1),
        .dout   (sq_re_s2)
    );

    signed_square_reg #(.WIDTH(DATA_WIDTH)) u_square_im (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .din    (im_s1),
        .dout   (sq_im_s2)
    );

    // S2 tag stage
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_s2 <= 1'b0;
        end else if (enable) begin
            valid_s2 <= valid_s1;
        end
    end

    // S3: output register, zeroed on invalid cycles, plus the frame counter
    always_ff @(posedge clock) begin
        if (reset) begin
            validOut    <= 1'b0;
            dataOut     <= '0;
            lastOut     <= 1'b0;
            frame_count <= '0;
        end else if (enable) begin
            validOut <= valid_s2;
            dataOut  <= valid_s2 ? sum_s2 : '0;
            lastOut  <= valid_s2 && frame_end;
            if (valid_s2) begin
                frame_count <= frame_end ? '0 : frame_count + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule
